// File: rtl/poly_eval_horner_pkg.sv
// Shared constants for the Horner polynomial evaluator: FSM encoding, MAC op codes
// and the index-width helper. Optional build macro: POLY_KEEP_COEF_EN.
package poly_eval_pkg;

  localparam int MAX_DEGREE = 15;

  typedef logic [3:0] state_t;

  localparam state_t ST_LOAD      = 4'd0;
  localparam state_t ST_LOAD_WAIT = 4'd1;
  localparam state_t ST_LDX       = 4'd2;
  localparam state_t ST_LDX_WAIT  = 4'd3;
  localparam state_t ST_INIT      = 4'd4;
  localparam state_t ST_MUL       = 4'd5;
  localparam state_t ST_ADD       = 4'd6;
  localparam state_t ST_DONE      = 4'd7;
  localparam state_t ST_DONE_WAIT = 4'd8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Bits needed to hold a coefficient index 0..d, never less than one.
  function automatic int idx_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/poly_eval_horner_if.sv
// Board-side bundle of the evaluator: Go/DataIn entry strobe plus result and status
// outputs. Optional build macro: POLY_KEEP_COEF_EN.
interface poly_eval_horner_if #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
);
  import poly_eval_pkg::*;

  localparam int IW = idx_width(DEGREE);

  logic             Go;
  logic [WIDTH-1:0] DataIn;
  logic [WIDTH-1:0] DataResult;
  logic             ResultValid;
  logic             Busy;
  logic [IW-1:0]    LoadIdx;
  logic             LoadingX;

  modport master (
    output Go, DataIn,
    input  DataResult, ResultValid, Busy, LoadIdx, LoadingX
  );

  modport slave (
    input  Go, DataIn,
    output DataResult, ResultValid, Busy, LoadIdx, LoadingX
  );

endinterface

// File: rtl/poly_eval_horner_mac.sv
// Single multiply/add datapath of the evaluator: holds acc and x, result truncated
// to WIDTH bits. Optional build macro: POLY_KEEP_COEF_EN (no effect here).
module poly_mac
  import poly_eval_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op,
  input  logic             ld_acc,
  input  logic             ld_x,
  input  logic             init,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] coef_in,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] sum;

  assign prod     = acc_q * x_q;
  assign sum      = acc_q + coef_in;
  assign result_o = (op == OP_ADD) ? sum : prod;

  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    if (init) begin
      acc_d = coef_in;
    end else if (ld_acc) begin
      acc_d = result_o;
    end
    if (ld_x) begin
      x_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      x_q   <= '0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
    end
  end

endmodule

// File: rtl/poly_eval_horner.sv
// Horner-rule polynomial evaluator: entry FSM for c[D]..c[0] and x, then INIT/MUL/ADD loop.
// Optional build macro: POLY_KEEP_COEF_EN (retain coefficients, restart at x entry).
module poly_eval_horner
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic                Clock,
  input  logic                Resetn,
  poly_eval_horner_if.slave   bus
);

  localparam int IW = idx_width(DEGREE);

  state_t           state_q, state_d;
  logic [IW-1:0]    load_idx_q, load_idx_d;
  logic [IW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] coef_q [0:DEGREE];
  logic [WIDTH-1:0] coef_d [0:DEGREE];

  logic             coef_we;
  logic             mac_op;
  logic             mac_ld_acc;
  logic             mac_ld_x;
  logic             mac_init;
  logic [WIDTH-1:0] coef_sel;
  logic [WIDTH-1:0] mac_result;

  // INIT seeds acc with the leading coefficient; ADD uses the one the step counter points at.
  assign coef_sel = mac_init ? coef_q[DEGREE] : coef_q[step_q];

  poly_mac #(.WIDTH(WIDTH)) u_mac (
    .clk      (Clock),
    .rst_n    (Resetn),
    .op       (mac_op),
    .ld_acc   (mac_ld_acc),
    .ld_x     (mac_ld_x),
    .init     (mac_init),
    .data_in  (bus.DataIn),
    .coef_in  (coef_sel),
    .result_o (mac_result)
  );

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    step_d     = step_q;
    result_d   = result_q;
    coef_we    = 1'b0;
    mac_op     = OP_MUL;
    mac_ld_acc = 1'b0;
    mac_ld_x   = 1'b0;
    mac_init   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (bus.Go) begin
          coef_we = 1'b1;
          state_d = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (!bus.Go) begin
          if (load_idx_q != '0) begin
            load_idx_d = load_idx_q - IW'(1);
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_LDX;
          end
        end
      end
      ST_LDX: begin
        if (bus.Go) begin
          mac_ld_x = 1'b1;
          state_d  = ST_LDX_WAIT;
        end
      end
      ST_LDX_WAIT: begin
        if (!bus.Go) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        mac_init = 1'b1;
        step_d   = IW'(DEGREE - 1);
        state_d  = ST_MUL;
      end
      ST_MUL: begin
        mac_ld_acc = 1'b1;
        mac_op     = OP_MUL;
        state_d    = ST_ADD;
      end
      ST_ADD: begin
        mac_ld_acc = 1'b1;
        mac_op     = OP_ADD;
        if (step_q == '0) begin
          result_d = mac_result;
          state_d  = ST_DONE;
        end else begin
          step_d  = step_q - IW'(1);
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (bus.Go) begin
          state_d = ST_DONE_WAIT;
        end
      end
      ST_DONE_WAIT: begin
        if (!bus.Go) begin
`ifdef POLY_KEEP_COEF_EN
          state_d = ST_LDX;
`else
          state_d    = ST_LOAD;
          load_idx_d = IW'(DEGREE);
`endif
        end
      end
      default: begin
        state_d    = ST_LOAD;
        load_idx_d = IW'(DEGREE);
      end
    endcase
  end

  always_comb begin
    coef_d = coef_q;
    if (coef_we) begin
      coef_d[load_idx_q] = bus.DataIn;
    end
  end

  for (genvar gi = 0; gi <= DEGREE; gi++) begin : g_coef
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        coef_q[gi] <= '0;
      end else begin
        coef_q[gi] <= coef_d[gi];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_LOAD;
      load_idx_q <= IW'(DEGREE);
      step_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      step_q     <= step_d;
      result_q   <= result_d;
    end
  end

  assign bus.DataResult  = result_q;
  assign bus.ResultValid = (state_q == ST_DONE);
  assign bus.Busy        = (state_q == ST_INIT) || (state_q == ST_MUL) || (state_q == ST_ADD);
  assign bus.LoadingX    = (state_q == ST_LDX) || (state_q == ST_LDX_WAIT);
  assign bus.LoadIdx     = load_idx_q;

endmodule
